// File: rtl/crypto_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : crypto_result_collector
// Purpose  : Shadows the enable-gated crypto accelerator pipeline with a
//            valid-bit shift register, captures each real result into a
//            FIFO exposed as a valid/ready stream, and raises a hold request
//            upstream whenever stored plus in-flight tokens fill the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module crypto_result_collector #(
    parameter int LATENCY = 9,
    parameter int DEPTH   = 8,
    parameter int DW      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         acc_en,
    input  logic                         acc_in_valid,
    input  logic [DW-1:0]                acc_data,
    output logic                         acc_hold,
    output logic                         m_valid,
    output logic [DW-1:0]                m_data,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic [$clog2(LATENCY)+1:0]   inflight,
    output logic                         overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_IW = $clog2(LATENCY) + 2;
    localparam int c_SW = ((c_CW > c_IW) ? c_CW : c_IW) + 1;
    localparam logic [c_AW:0]   c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_SW-1:0] c_DEPTH_S = c_SW'(DEPTH);

    // Shadow of the accelerator pipe: r_vld[k] marks a real token in stage k.
    // r_fresh is set only after an enabled edge, so a result parked at the
    // last stage is pushed exactly once.
    logic [LATENCY:1]   r_vld;
    logic               r_fresh;

    logic [DW-1:0]      r_mem [DEPTH];
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic               r_overflow;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_en;
    logic               w_drop;
    logic [c_IW-1:0]    w_inflight;
    logic [c_SW-1:0]    w_occupancy;

    assign w_push  = r_fresh & r_vld[LATENCY];
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_pop   = m_valid & m_ready;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle: the write lands in the slot being vacated.
    assign w_wr_en = ~flush & w_push & (~w_full | w_pop);
    assign w_drop  = ~flush & w_push & w_full & ~w_pop;

    assign m_valid    = ~w_empty;
    assign m_data     = m_valid ? r_mem[r_rd_ptr[c_AW-1:0]] : '0;
    assign fifo_count = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign inflight   = w_inflight;

    // Advance the valid shadow in lock-step with the accelerator enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_fresh <= 1'b0;
        end else if (flush) begin
            r_vld   <= '0;
            r_fresh <= 1'b0;
        end else if (acc_en) begin
            r_vld   <= {r_vld[LATENCY-1:1], acc_in_valid};
            r_fresh <= 1'b1;
        end else begin
            r_fresh <= 1'b0;
        end
    end

    // Result storage; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= acc_data;
        end
    end

    // FIFO pointers carry a wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Sticky record that a result was lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Count tokens still owed to the FIFO: every shadow stage before the last,
    // plus the last stage only while its push is still pending.
    always_comb begin
        w_inflight = '0;
        for (int k = 1; k < LATENCY; k++) begin
            w_inflight = w_inflight + c_IW'(r_vld[k]);
        end
        w_inflight = w_inflight + c_IW'(r_vld[LATENCY] & r_fresh);
    end

    // Hold upstream once every FIFO slot is either filled or reserved.
    always_comb begin
        w_occupancy = c_SW'(fifo_count) + c_SW'(w_inflight);
        acc_hold    = (w_occupancy >= c_DEPTH_S);
    end

endmodule
`default_nettype wire

// File: tb/tb_crypto_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_crypto_result_collector
// Purpose  : Self-checking bench for crypto_result_collector: a per-cycle
//            vector table for latency and enable gaps, plus directed
//            sequences for hold, wrap, overflow, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crypto_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        acc_en;
    logic        acc_in_valid;
    logic [63:0] acc_data;
    logic        acc_hold;
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_ready;
    logic [3:0]  fifo_count;
    logic [5:0]  inflight;
    logic        overflow;

    crypto_result_collector #(.LATENCY(9), .DEPTH(8), .DW(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .acc_en       (acc_en),
        .acc_in_valid (acc_in_valid),
        .acc_data     (acc_data),
        .acc_hold     (acc_hold),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .fifo_count   (fifo_count),
        .inflight     (inflight),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        iv;
        logic        rdy;
        logic [63:0] data;
        logic        ev;
        logic [63:0] ed;
        logic [3:0]  ecnt;
        logic [5:0]  einf;
        logic        ehold;
        logic        eovf;
    } vec_t;

    vec_t        tbl[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] apipe [1:9];
    bit          use_model;
    logic [63:0] payload;
    logic [63:0] expq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: wait for the edge, then model the accelerator's data path.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc_en) begin
            for (int k = 9; k > 1; k--) apipe[k] = apipe[k-1];
            apipe[1] = acc_in_valid ? payload : 64'h0;
        end
        if (use_model) acc_data = apipe[9];
    endtask

    task automatic admit(input logic [63:0] val, input bit kept);
        acc_en = 1'b1;
        acc_in_valid = 1'b1;
        payload = val;
        if (kept) expq.push_back(val);
        tick();
        acc_in_valid = 1'b0;
    endtask

    task automatic bubbles(input int n);
        acc_en = 1'b1;
        acc_in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pop_all(input int n);
        acc_en = 1'b0;
        acc_in_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("pop_valid", m_valid, 1'b1);
            if (expq.size() > 0) begin
                chk("pop_data", m_data, expq[0]);
                expq.pop_front();
            end
            tick();
        end
        m_ready = 1'b0;
    endtask

    function automatic vec_t mk(logic en, logic iv, logic rdy, logic [63:0] d,
                                logic ev, logic [63:0] ed, logic [3:0] ec,
                                logic [5:0] ei, logic eh, logic eo);
        vec_t v;
        v.en = en; v.iv = iv; v.rdy = rdy; v.data = d;
        v.ev = ev; v.ed = ed; v.ecnt = ec; v.einf = ei; v.ehold = eh; v.eovf = eo;
        return v;
    endfunction

    initial begin
        int admitted;
        int sent;
        int got;
        int full_chk;
        bit full_seen;

        // Single token with continuous enable, consumer ready
        tbl.push_back(mk(1, 1, 1, 64'h0, 0, 64'h0, 0, 1, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 1, 64'h0, 0, 64'h0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 64'hDEAD_BEEF_0000_0001, 1, 64'hDEAD_BEEF_0000_0001, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 64'h0, 0, 64'h0, 0, 0, 0, 0));
        // Same token with enable gaps, consumer stalled
        tbl.push_back(mk(1, 1, 0, 64'h2, 0, 64'h0, 0, 1, 0, 0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0, 0, 0, 64'h2, 0, 64'h0, 0, 1, 0, 0));
            tbl.push_back(mk(0, 0, 0, 64'h2, 0, 64'h0, 0, 1, 0, 0));
            tbl.push_back(mk(1, 0, 0, 64'h2, 0, 64'h0, 0, 1, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 64'h2, 1, 64'h2, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 64'h2, 1, 64'h2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 64'h2, 1, 64'h2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 64'h0, 0, 64'h0, 0, 0, 0, 0));

        for (int k = 1; k <= 9; k++) apipe[k] = 64'h0;
        use_model = 1'b0;
        payload = 64'h0;
        rst = 1'b1; flush = 1'b0; acc_en = 1'b0; acc_in_valid = 1'b0;
        acc_data = 64'h0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_hold", acc_hold, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven latency and enable-gap vectors
        for (int i = 0; i < tbl.size(); i++) begin
            acc_en = tbl[i].en;
            acc_in_valid = tbl[i].iv;
            m_ready = tbl[i].rdy;
            acc_data = tbl[i].data;
            tick();
            chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("vec%0d_data", i), m_data, tbl[i].ed);
            chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].ecnt);
            chk($sformatf("vec%0d_inflight", i), inflight, tbl[i].einf);
            chk($sformatf("vec%0d_hold", i), acc_hold, tbl[i].ehold);
            chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].eovf);
        end

        // Hold: continuous tokens honouring acc_hold, consumer stalled
        use_model = 1'b1;
        m_ready = 1'b0;
        admitted = 0;
        for (int c = 0; c < 12; c++) begin
            acc_en = 1'b1;
            acc_in_valid = ~acc_hold;
            if (acc_in_valid) begin
                admitted++;
                payload = 64'hA000 + 64'(admitted);
                expq.push_back(payload);
            end
            tick();
            chk("hold_occ", 64'(fifo_count) + 64'(inflight), 64'(admitted));
            chk("hold_level", acc_hold, admitted >= 8);
        end
        bubbles(10);
        chk("hold_count", fifo_count, 8);
        chk("hold_inflight", inflight, 0);
        chk("hold_ovf", overflow, 0);
        chk("hold_high", acc_hold, 1);
        pop_all(1);
        chk("hold_count7", fifo_count, 7);
        chk("hold_low", acc_hold, 0);
        pop_all(7);
        chk("hold_drained", fifo_count, 0);

        // Full with simultaneous push/pop, values 1..16 across pointer wrap
        sent = 0; got = 0; full_chk = 0; full_seen = 1'b0;
        m_ready = 1'b0;
        for (int c = 0; c < 80 && got < 16; c++) begin
            acc_en = 1'b1;
            acc_in_valid = (sent < 16);
            if (acc_in_valid) begin
                sent++;
                payload = 64'(sent);
                expq.push_back(payload);
            end
            if (m_valid && m_ready) begin
                chk("wrap_data", m_data, expq[0]);
                expq.pop_front();
                got++;
            end
            tick();
            if (full_seen && full_chk < 8) begin
                chk("wrap_full_count", fifo_count, 8);
                full_chk++;
            end
            if (!full_seen && fifo_count == 4'd8) begin
                full_seen = 1'b1;
                m_ready = 1'b1;
            end
        end
        chk("wrap_transfers", got, 16);
        chk("wrap_full_checks", full_chk, 8);
        chk("wrap_ovf", overflow, 0);
        chk("wrap_empty", fifo_count, 0);
        m_ready = 1'b0;
        expq.delete();

        // Forced overflow: ninth token injected ignoring acc_hold
        for (int i = 1; i <= 8; i++) admit(64'hB000 + 64'(i), 1'b1);
        chk("ovf_hold", acc_hold, 1);
        bubbles(9);
        chk("ovf_count_pre", fifo_count, 8);
        chk("ovf_pre", overflow, 0);
        admit(64'hB009, 1'b0);
        bubbles(9);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", fifo_count, 8);
        pop_all(8);
        chk("ovf_empty", fifo_count, 0);
        chk("ovf_sticky", overflow, 1);

        // Flush with 2 stored and 3 in flight
        admit(64'hC001, 1'b0);
        admit(64'hC002, 1'b0);
        bubbles(9);
        admit(64'hC003, 1'b0);
        admit(64'hC004, 1'b0);
        admit(64'hC005, 1'b0);
        chk("fl_count_pre", fifo_count, 2);
        chk("fl_inflight_pre", inflight, 3);
        acc_en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", m_valid, 0);
        chk("fl_inflight", inflight, 0);
        chk("fl_count", fifo_count, 0);
        chk("fl_ovf", overflow, 1);
        bubbles(12);
        chk("fl_no_ghost", fifo_count, 0);

        // Asynchronous reset mid-stream
        admit(64'hD001, 1'b0);
        bubbles(9);
        admit(64'hD002, 1'b0);
        admit(64'hD003, 1'b0);
        acc_en = 1'b0;
        chk("ar_count_pre", fifo_count, 1);
        chk("ar_data_pre", m_data, 64'hD001);
        chk("ar_inflight_pre", inflight, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", m_valid, 0);
        chk("ar_data", m_data, 0);
        chk("ar_count", fifo_count, 0);
        chk("ar_inflight", inflight, 0);
        chk("ar_ovf", overflow, 0);
        chk("ar_hold", acc_hold, 0);
        #1;
        rst = 1'b0;
        bubbles(10);
        chk("ar_after", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
